param_cache: RTL and testbench

- Parametrised, set-associative, write-back, write-allocate data cache. Successor to the fixed single-configuration cache.
- Sits between the CPU-side controller and the backing RAM model.
- Adds configurable sets, ways, data and address width, byte-enable writes, dirty-line write-back and round-robin replacement.
- Line size is one DATA_W word.

---
 rtl/param_cache_pkg.sv | 39 +++
 rtl/cache_way_array.sv | 53 +++++
 rtl/param_cache.sv | 216 +++++++++++++++++++++
 tb/tb_param_cache.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_cache_pkg.sv
// Shared types and helpers for the parametrised set-associative cache.
package param_cache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COMPARE,
      WRITEBACK,
      REFILL,
      RESPOND
   } state_t;

   // Byte-offset width for a line of data_w bits (line = one word).
   function automatic int calc_off_w(input int data_w);
      return $clog2(data_w / 8);
   endfunction

   // Set-index width.
   function automatic int calc_idx_w(input int sets);
      return $clog2(sets);
   endfunction

   // Tag width = whatever is left above index and offset.
   function automatic int calc_tag_w(input int addr_w, input int data_w, input int sets);
      return addr_w - calc_off_w(data_w) - calc_idx_w(sets);
   endfunction

   // Way-index width; kept at least one bit so direct-mapped still has a legal vector.
   function automatic int calc_way_w(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

   // Merge one byte lane: take the new byte when its enable is set.
   function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                             input logic [7:0] new_b,
                                             input logic       en);
      return en ? new_b : old_b;
   endfunction

endpackage

// File: rtl/cache_way_array.sv
// One way of the cache: per-set tag/valid/dirty/data with a single write
// port and combinational read addressed by the set index.
module cache_way_array
   import param_cache_pkg::*;
#(
   parameter int SETS   = 16,
   parameter int IDX_W  = 4,
   parameter int TAG_W  = 25,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_ni,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic              wr_en_i,
   input  logic [TAG_W-1:0]  wr_tag_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              wr_dirty_i,
   output logic              valid_o,
   output logic              dirty_o,
   output logic [TAG_W-1:0]  tag_o,
   output logic [DATA_W-1:0] data_o
);

   logic [SETS-1:0]   valid_q;
   logic [SETS-1:0]   dirty_q;
   logic [TAG_W-1:0]  tag_mem  [SETS];
   logic [DATA_W-1:0] data_mem [SETS];

   // Valid/dirty flags need a clean reset; writing a line marks it valid.
   always_ff @(posedge clk) begin
      if (!rst_ni) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (wr_en_i) begin
         valid_q[idx_i] <= 1'b1;
         dirty_q[idx_i] <= wr_dirty_i;
      end
   end

   // Tag and data storage carry no reset; they are qualified by valid.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         tag_mem[idx_i]  <= wr_tag_i;
         data_mem[idx_i] <= wr_data_i;
      end
   end

   assign valid_o = valid_q[idx_i];
   assign dirty_o = dirty_q[idx_i];
   assign tag_o   = tag_mem[idx_i];
   assign data_o  = data_mem[idx_i];

endmodule

// File: rtl/param_cache.sv
// Set-associative, write-back, write-allocate cache with byte-enable writes
// and per-set round-robin replacement. One word per line.
module param_cache
   import param_cache_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int SETS   = 16,
   parameter int WAYS   = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cpu_read,
   input  logic                cpu_write,
   input  logic [ADDR_W-1:0]   cpu_address,
   input  logic [DATA_W-1:0]   cpu_write_data,
   input  logic [DATA_W/8-1:0] cpu_byte_en,
   output logic                cpu_ready,
   output logic                cpu_done,
   output logic [DATA_W-1:0]   cpu_read_data,
   output logic                hit,
   output logic                miss,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W-1:0]   mem_write_data,
   input  logic                mem_ready,
   input  logic [DATA_W-1:0]   mem_read_data
);

   localparam int OFF_W = calc_off_w(DATA_W);
   localparam int IDX_W = calc_idx_w(SETS);
   localparam int TAG_W = calc_tag_w(ADDR_W, DATA_W, SETS);
   localparam int WAY_W = calc_way_w(WAYS);
   localparam int NB    = DATA_W / 8;
   localparam int WA_W  = ADDR_W - OFF_W;

   state_t            state_q, state_d;
   logic [WA_W-1:0]   waddr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [NB-1:0]     be_q;
   logic              write_q;
   logic [DATA_W-1:0] resp_q;
   logic [WAY_W-1:0]  victim_q, victim_d;
   logic [WAY_W-1:0]  rr_q [SETS];

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [NB-1:0]     eff_be;

   logic [WAYS-1:0]   rd_valid;
   logic [WAYS-1:0]   rd_dirty;
   logic [TAG_W-1:0]  rd_tag  [WAYS];
   logic [DATA_W-1:0] rd_data [WAYS];

   logic [WAYS-1:0]   wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              wr_dirty;

   logic              hit_any;
   logic [WAY_W-1:0]  hit_way;
   logic [WAY_W-1:0]  victim_sel;
   logic [DATA_W-1:0] hit_line;
   logic [DATA_W-1:0] merged_hit;
   logic [DATA_W-1:0] merged_fill;

   // The byte offset never reaches the storage; lines are whole words.
   logic unused_offset_bits;
   assign unused_offset_bits = ^cpu_address[OFF_W-1:0];

   assign idx      = waddr_q[IDX_W-1:0];
   assign tag      = waddr_q[WA_W-1:IDX_W];
   assign eff_be   = write_q ? be_q : '0;
   assign hit_line = rd_data[hit_way];

   for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      cache_way_array #(
         .SETS   (SETS),
         .IDX_W  (IDX_W),
         .TAG_W  (TAG_W),
         .DATA_W (DATA_W)
      ) u_way (
         .clk        (clk),
         .rst_ni     (rst),
         .idx_i      (idx),
         .wr_en_i    (wr_en[gi]),
         .wr_tag_i   (tag),
         .wr_data_i  (wr_data),
         .wr_dirty_i (wr_dirty),
         .valid_o    (rd_valid[gi]),
         .dirty_o    (rd_dirty[gi]),
         .tag_o      (rd_tag[gi]),
         .data_o     (rd_data[gi])
      );
   end

   for (genvar gi = 0; gi < NB; gi++) begin : g_merge
      assign merged_hit[gi*8 +: 8]  = merge_byte(hit_line[gi*8 +: 8], wdata_q[gi*8 +: 8], eff_be[gi]);
      assign merged_fill[gi*8 +: 8] = merge_byte(mem_read_data[gi*8 +: 8], wdata_q[gi*8 +: 8], eff_be[gi]);
   end

   // Tag match across ways, and victim choice: lowest invalid way, else the set pointer.
   always_comb begin
      hit_any    = 1'b0;
      hit_way    = '0;
      victim_sel = rr_q[idx];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (rd_valid[w] && (rd_tag[w] == tag)) begin
            hit_any = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!rd_valid[w]) begin
            victim_sel = WAY_W'(w);
         end
      end
   end

   // Next-state, CPU/memory outputs and way write strobes.
   always_comb begin
      state_d        = state_q;
      victim_d       = victim_q;
      cpu_ready      = 1'b0;
      cpu_done       = 1'b0;
      cpu_read_data  = '0;
      hit            = 1'b0;
      miss           = 1'b0;
      mem_req        = 1'b0;
      mem_we         = 1'b0;
      mem_address    = '0;
      mem_write_data = '0;
      wr_en          = '0;
      wr_data        = merged_fill;
      wr_dirty       = 1'b0;
      case (state_q)
         IDLE: begin
            cpu_ready = 1'b1;
            if (cpu_read || cpu_write) begin
               state_d = COMPARE;
            end
         end
         COMPARE: begin
            if (hit_any) begin
               hit           = 1'b1;
               cpu_done      = 1'b1;
               cpu_read_data = merged_hit;
               if (write_q) begin
                  wr_en[hit_way] = 1'b1;
                  wr_data        = merged_hit;
                  wr_dirty       = rd_dirty[hit_way] | (|be_q);
               end
               state_d = IDLE;
            end else begin
               miss     = 1'b1;
               victim_d = victim_sel;
               state_d  = (rd_valid[victim_sel] && rd_dirty[victim_sel]) ? WRITEBACK : REFILL;
            end
         end
         WRITEBACK: begin
            mem_req        = 1'b1;
            mem_we         = 1'b1;
            mem_address    = {rd_tag[victim_q], idx, {OFF_W{1'b0}}};
            mem_write_data = rd_data[victim_q];
            if (mem_ready) begin
               state_d = REFILL;
            end
         end
         REFILL: begin
            mem_req     = 1'b1;
            mem_address = {waddr_q, {OFF_W{1'b0}}};
            if (mem_ready) begin
               wr_en[victim_q] = 1'b1;
               wr_data         = merged_fill;
               wr_dirty        = write_q & (|be_q);
               state_d         = RESPOND;
            end
         end
         RESPOND: begin
            cpu_done      = 1'b1;
            cpu_read_data = resp_q;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, victim and replacement pointers; pointer advances only when a valid line is evicted.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         victim_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            rr_q[s] <= '0;
         end
      end else begin
         state_q  <= state_d;
         victim_q <= victim_d;
         if ((state_q == REFILL) && mem_ready && rd_valid[victim_q]) begin
            rr_q[idx] <= (rr_q[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx] + 1'b1;
         end
      end
   end

   // Request capture in IDLE and the installed line held for RESPOND.
   always_ff @(posedge clk) begin
      if ((state_q == IDLE) && (cpu_read || cpu_write)) begin
         waddr_q <= cpu_address[ADDR_W-1:OFF_W];
         wdata_q <= cpu_write_data;
         be_q    <= cpu_byte_en;
         write_q <= cpu_write;
      end
      if ((state_q == REFILL) && mem_ready) begin
         resp_q <= merged_fill;
      end
   end

endmodule

// File: tb/tb_param_cache.sv
// Bench for param_cache (default parameters): directed cases then random
// traffic, checked against a flat-memory plus cache-contents model.
module tb_param_cache;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cpu_read = 1'b0;
   logic        cpu_write = 1'b0;
   logic [31:0] cpu_address = '0;
   logic [63:0] cpu_write_data = '0;
   logic [7:0]  cpu_byte_en = '0;
   logic        cpu_ready;
   logic        cpu_done;
   logic [63:0] cpu_read_data;
   logic        hit;
   logic        miss;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_address;
   logic [63:0] mem_write_data;
   logic        mem_ready = 1'b0;
   logic [63:0] mem_read_data = '0;

   param_cache dut (
      .clk            (clk),
      .rst            (rst),
      .cpu_read       (cpu_read),
      .cpu_write      (cpu_write),
      .cpu_address    (cpu_address),
      .cpu_write_data (cpu_write_data),
      .cpu_byte_en    (cpu_byte_en),
      .cpu_ready      (cpu_ready),
      .cpu_done       (cpu_done),
      .cpu_read_data  (cpu_read_data),
      .hit            (hit),
      .miss           (miss),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_ready      (mem_ready),
      .mem_read_data  (mem_read_data)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int n_txn    = 0;

   // Model: backing memory, CPU-visible memory, and which words each set holds.
   logic [63:0] backing [bit [28:0]];
   logic [63:0] gold    [bit [28:0]];
   bit          m_valid [16][2];
   bit          m_dirty [16][2];
   logic [24:0] m_tag   [16][2];
   int          m_rr    [16];

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mmerge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] be);
      logic [63:0] r;
      r = o;
      for (int i = 0; i < 8; i++) begin
         if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
      end
      return r;
   endfunction

   function automatic logic [63:0] line_value(input bit [28:0] wa);
      if (!backing.exists(wa)) begin
         backing[wa] = {$urandom, $urandom};
         gold[wa]    = backing[wa];
      end
      return backing[wa];
   endfunction

   // Reset discards cache contents, so unwritten-back data is lost.
   task automatic reset_model();
      for (int s = 0; s < 16; s++) begin
         m_rr[s] = 0;
         for (int w = 0; w < 2; w++) begin
            m_valid[s][w] = 1'b0;
            m_dirty[s][w] = 1'b0;
         end
      end
      foreach (backing[k]) gold[k] = backing[k];
   endtask

   task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [63:0] wd, input logic [7:0] be,
                      input int d_wb, input int d_rf,
                      input bit force_fill, input logic [63:0] fill_val);
      bit [28:0]   wa;
      bit [28:0]   vwa;
      int          set;
      logic [24:0] tg;
      int          hw;
      int          v;
      bit          do_wb;
      logic [63:0] nv;
      logic [63:0] base;
      wa    = addr[31:3];
      set   = int'(addr[6:3]);
      tg    = addr[31:7];
      hw    = -1;
      do_wb = 1'b0;
      for (int w = 0; w < 2; w++) begin
         if (m_valid[set][w] && m_tag[set][w] == tg) hw = w;
      end
      @(negedge clk);
      chk1("idle_ready", cpu_ready, 1'b1);
      cpu_read       = rd;
      cpu_write      = wr;
      cpu_address    = addr;
      cpu_write_data = wd;
      cpu_byte_en    = be;
      mem_ready      = (hw >= 0);
      @(posedge clk);
      @(negedge clk);
      cpu_read       = 1'b0;
      cpu_write      = 1'b0;
      cpu_write_data = ~wd;
      cpu_byte_en    = ~be;
      chk1("hit_pulse", hit, hw >= 0);
      chk1("miss_pulse", miss, hw < 0);
      if (hw >= 0) begin
         nv = wr ? mmerge(gold[wa], wd, be) : gold[wa];
         chk1("hit_done", cpu_done, 1'b1);
         chk64("hit_data", cpu_read_data, nv);
         chk1("hit_memreq", mem_req, 1'b0);
         mem_ready = 1'b0;
         if (wr) begin
            gold[wa] = nv;
            if (be != 8'h00) m_dirty[set][hw] = 1'b1;
         end
      end else begin
         chk1("miss_done", cpu_done, 1'b0);
         v = -1;
         for (int w = 1; w >= 0; w--) begin
            if (!m_valid[set][w]) v = w;
         end
         if (v < 0) v = m_rr[set];
         do_wb = m_valid[set][v] && m_dirty[set][v];
         vwa   = {m_tag[set][v], 4'(set)};
         if (do_wb) begin
            for (int k = 0; k <= d_wb; k++) begin
               @(posedge clk);
               @(negedge clk);
               mem_ready = 1'b0;
               chk1("wb_req", mem_req, 1'b1);
               chk1("wb_we", mem_we, 1'b1);
               chk64("wb_addr", 64'(mem_address), 64'({vwa, 3'b000}));
               chk64("wb_data", mem_write_data, gold[vwa]);
               chk1("wb_busy", cpu_ready, 1'b0);
               if (k == d_wb) mem_ready = 1'b1;
            end
            backing[vwa] = gold[vwa];
         end
         if (force_fill) begin
            backing[wa] = fill_val;
            gold[wa]    = fill_val;
         end
         base = line_value(wa);
         for (int k = 0; k <= d_rf; k++) begin
            @(posedge clk);
            @(negedge clk);
            mem_ready     = 1'b0;
            mem_read_data = {$urandom, $urandom};
            cpu_read      = 1'b1;
            cpu_address   = $urandom;
            chk1("rf_req", mem_req, 1'b1);
            chk1("rf_we", mem_we, 1'b0);
            chk64("rf_addr", 64'(mem_address), 64'({wa, 3'b000}));
            chk1("rf_busy", cpu_ready, 1'b0);
            if (k == d_rf) begin
               mem_ready     = 1'b1;
               mem_read_data = base;
            end
         end
         @(posedge clk);
         @(negedge clk);
         mem_ready = 1'b0;
         cpu_read  = 1'b0;
         nv = wr ? mmerge(base, wd, be) : base;
         chk1("resp_done", cpu_done, 1'b1);
         chk64("resp_data", cpu_read_data, nv);
         chk1("resp_memreq", mem_req, 1'b0);
         if (m_valid[set][v]) m_rr[set] = (m_rr[set] + 1) % 2;
         m_valid[set][v] = 1'b1;
         m_tag[set][v]   = tg;
         m_dirty[set][v] = wr && (be != 8'h00);
         gold[wa]        = nv;
      end
      n_txn++;
      $display("txn %0d: %s addr=0x%08h be=0x%02h %s%s data=0x%016h", n_txn,
               wr ? "WR" : "RD", addr, be, (hw >= 0) ? "hit" : "miss",
               do_wb ? "+wb" : "", nv);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_model();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk1("rst_ready", cpu_ready, 1'b1);
      chk1("rst_done", cpu_done, 1'b0);
      chk1("rst_hit", hit, 1'b0);
      chk1("rst_miss", miss, 1'b0);
      chk1("rst_memreq", mem_req, 1'b0);
      chk1("rst_memwe", mem_we, 1'b0);
      chk64("rst_rdata", cpu_read_data, 64'h0);
      rst = 1'b1;

      // Cold read then reread.
      txn(1, 0, 32'h40, 64'h0, 8'h00, 0, 2, 1, 64'hAAAA_AAAA_AAAA_AAAA);
      txn(1, 0, 32'h40, 64'h0, 8'hFF, 0, 0, 0, 64'h0);
      // Partial write allocate, then read back.
      txn(0, 1, 32'h08, 64'h1122_3344_5566_7788, 8'h0F, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
      txn(1, 0, 32'h08, 64'h0, 8'h00, 0, 0, 0, 64'h0);
      // Dirty way0, clean way1, conflict forcing write-back, then pointer-selected eviction.
      txn(0, 1, 32'h000, 64'hDEAD_BEEF_0123_4567, 8'hFF, 0, 0, 0, 64'h0);
      txn(1, 0, 32'h080, 64'h0, 8'h00, 0, 1, 0, 64'h0);
      txn(1, 0, 32'h100, 64'h0, 8'h00, 2, 1, 0, 64'h0);
      txn(1, 0, 32'h000, 64'h0, 8'h00, 0, 0, 0, 64'h0);
      txn(1, 0, 32'h100, 64'h0, 8'h00, 0, 0, 0, 64'h0);
      // Long memory stall during refill.
      txn(1, 0, 32'h300, 64'h0, 8'h00, 0, 6, 0, 64'h0);

      // Reset in the middle of a refill.
      @(negedge clk);
      cpu_read    = 1'b1;
      cpu_address = 32'h200;
      @(posedge clk);
      @(negedge clk);
      cpu_read = 1'b0;
      chk1("rstmid_miss", miss, 1'b1);
      @(posedge clk);
      @(negedge clk);
      chk1("rstmid_req", mem_req, 1'b1);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk1("rstmid_ready", cpu_ready, 1'b1);
      chk1("rstmid_memreq", mem_req, 1'b0);
      chk1("rstmid_done", cpu_done, 1'b0);
      rst = 1'b1;
      reset_model();
      txn(1, 0, 32'h040, 64'h0, 8'h00, 0, 0, 0, 64'h0);

      // Read and write together behave as a write.
      txn(1, 1, 32'h10, 64'h0000_0000_0000_005A, 8'h01, 0, 0, 0, 64'h0);
      txn(1, 0, 32'h10, 64'h0, 8'h00, 0, 0, 0, 64'h0);
      // Zero byte-enable write on a miss allocates clean.
      txn(0, 1, 32'h388, 64'h1234, 8'h00, 0, 0, 0, 64'h0);

      // Random traffic over a few sets with conflicting tags.
      for (int i = 0; i < 200; i++) begin
         logic [31:0] a;
         int          op;
         logic [7:0]  be;
         a  = ($urandom_range(0, 5) << 7) | ($urandom_range(0, 3) << 3) | $urandom_range(0, 7);
         op = $urandom_range(0, 2);
         be = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         txn(op != 1, op != 0, a, {$urandom, $urandom}, be,
             $urandom_range(0, 3), $urandom_range(0, 3), 0, 64'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
